l2_block_mem: RTL and testbench
===============================

Name: l2_block_mem

Overview:
- Behavioural L2/backing-store responder directly downstream of the L1 cache controller.
- Services the controller's line-fill requests (read_l2 → l2_ack) and dirty-line write-backs (write_l2 → write_done).
- Transfers whole cache lines, one 32-bit word per cycle, after a configurable access latency.
- Gives the L1 FSM realistic multi-cycle Allocate and WriteBack residency for integration and verification.

Parameters:
- BLOCK_WORDS, 4: 32-bit words per cache line; power of 2, ≥1.
- LATENCY, 4: access-delay cycles before the first word moves; ≥1.
- DEPTH_WORDS, 1024: backing-store size in 32-bit words; power of 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- read_l2  in  1  line-fill request, level, held by controller until l2_ack.
- write_l2  in  1  write-back request, level, held by controller until write_done.
- addr  in  32  byte address of the line; offset bits ignored.
- wdata  in  32*BLOCK_WORDS  write-back line; word k = bits [32k+31:32k].
- rdata  out  32*BLOCK_WORDS  fetched line, same packing; valid when l2_ack=1.
- l2_ack  out  1  one-cycle pulse, fill complete.
- write_done  out  1  one-cycle pulse, write-back complete.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: clk and reset as decided; reset is synchronous, active-high.
  - State → IDLE; l2_ack=0, write_done=0, busy=0, rdata=0, counters=0.
  - Backing array is not cleared by reset. Simulation initial content: word i = i.
- Address mapping:
  - base = ((addr >> 2) & ~(BLOCK_WORDS-1)) mod DEPTH_WORDS.
  - Word k of the line is at index (base + k) mod DEPTH_WORDS.
- States: IDLE, RD_WAIT, RD_XFER, RD_DONE, WR_WAIT, WR_XFER, WR_DONE. All outputs are Moore-decoded or registered; no combinational path from inputs to outputs.
- IDLE:
  - write_l2=1 → latch addr base and wdata; go to WR_WAIT.
  - Else read_l2=1 → latch base; go to RD_WAIT.
  - Write has priority when both are high.
- Timing (call the IDLE cycle in which a request is sampled "cycle 0"):
  - *_WAIT: cycles 1..LATENCY, latency counter runs.
  - *_XFER: cycles LATENCY+1..LATENCY+BLOCK_WORDS.
    - Read: word k is copied from the array into rdata slice k.
    - Write: wdata slice k is written to the array.
    - Words move in order k=0 first.
  - *_DONE: cycle LATENCY+BLOCK_WORDS+1. RD_DONE drives l2_ack=1; WR_DONE drives write_done=1, exactly one cycle. Next state is IDLE unconditionally.
  - Default (4,4): response pulse in cycle 9.
- After DONE, IDLE samples requests again the next cycle. A controller that drops its request on the ack edge is never re-served.
- Requests are latched at cycle 0. Changes to addr, wdata or request lines during WAIT/XFER are ignored.
- A request that drops mid-transaction does not abort it.
- rdata:
  - Intermediate values during RD_XFER are not guaranteed.
  - Holds the last completed line from RD_DONE until the next RD_XFER.
  - Unaffected by writes.
- Write-then-read of the same line returns the newly written data; writes are fully committed before write_done.
- Reset mid-operation:
  - Immediate return to IDLE; no ack or done pulse is issued.
  - Words already written during WR_XFER remain in the array; remaining words are unchanged.
- busy=1 from cycle 1 through the DONE cycle inclusive.

Test Plan:
- Read hit timing: read_l2=1 with addr=0x0000_0040, defaults → base 16; l2_ack high only in cycle 9; rdata = {19,18,17,16} (word3..word0); busy high in cycles 1-9.
- Write-back then fill: write_l2, addr=0x40, wdata={D,C,B,A}; write_done in cycle 9. Then read_l2, addr=0x40 → rdata={D,C,B,A}; neighbouring line 0x50 still reads {23,22,21,20}.
- Alignment and wrap:
  - addr=0x4C → same line as 0x40, rdata {19,18,17,16}.
  - addr=0x1000 with DEPTH_WORDS=1024 → base 0, rdata {3,2,1,0}.
- Simultaneous requests: read_l2=write_l2=1 in cycle 0 → write served first (write_done cycle 9). With read held, the read starts in cycle 10 and l2_ack occurs in cycle 19.
- Reset mid-write: reset asserted in cycle 6 (during WR_XFER, words 0-1 written) → IDLE next cycle; write_done never pulses. Readback of the line shows new word0/word1 and original word2/word3.
- Parameter sweep: LATENCY=1, BLOCK_WORDS=1 → ack in cycle 3. LATENCY=7, BLOCK_WORDS=8 → ack in cycle 16. No pulse is ever wider than one cycle.

Source files
------------

// File: rtl/l2_block_mem_if.sv
// l2_block_mem_if: line-transfer bus between the L1 controller
// (master) and the L2 backing store (slave).
interface l2_block_mem_if #(
  parameter int BLOCK_WORDS = 4
);
  logic                      read_l2;
  logic                      write_l2;
  logic [31:0]               addr;
  logic [32*BLOCK_WORDS-1:0] wdata;
  logic [32*BLOCK_WORDS-1:0] rdata;
  logic                      l2_ack;
  logic                      write_done;
  logic                      busy;

  modport master (
    output read_l2, write_l2, addr, wdata,
    input  rdata, l2_ack, write_done, busy
  );

  modport slave (
    input  read_l2, write_l2, addr, wdata,
    output rdata, l2_ack, write_done, busy
  );
endinterface

// File: rtl/l2_block_mem.sv
// l2_block_mem: behavioural L2 responder; moves whole lines one word
// per cycle after LATENCY wait cycles. Array words are stored XORed
// with their index so an all-zero array reads back as word i = i.
module l2_block_mem #(
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic          clk,
  input  logic          reset,
  l2_block_mem_if.slave bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [AW-1:0] OFF_MASK  = AW'(BLOCK_WORDS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(BLOCK_WORDS - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_XFER,
    RD_DONE,
    WR_WAIT,
    WR_XFER,
    WR_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] base_q, base_d;
  logic          wbuf_ld;

  logic [31:0] wbuf_q [BLOCK_WORDS];
  logic [31:0] rbuf_q [BLOCK_WORDS];
  logic [31:0] mem_q  [DEPTH_WORDS] = '{default: 32'd0};

  logic [AW-1:0] word_addr;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          unused_addr;

  assign word_addr   = bus.addr[AW+1:2];
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};
  assign idx         = base_q + AW'(wcnt_q);
  assign rd_word     = mem_q[idx] ^ 32'(idx);

  // Next-state: write wins in IDLE; WAIT then XFER then one DONE cycle
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    wcnt_d  = wcnt_q;
    base_d  = base_q;
    wbuf_ld = 1'b0;
    unique case (state_q)
      IDLE: begin
        lcnt_d = '0;
        wcnt_d = '0;
        if (bus.write_l2) begin
          base_d  = word_addr & ~OFF_MASK;
          wbuf_ld = 1'b1;
          state_d = WR_WAIT;
        end else if (bus.read_l2) begin
          base_d  = word_addr & ~OFF_MASK;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lcnt_q == LAT_LAST) state_d = RD_XFER;
        else lcnt_d = lcnt_q + 1'b1;
      end
      WR_WAIT: begin
        if (lcnt_q == LAT_LAST) state_d = WR_XFER;
        else lcnt_d = lcnt_q + 1'b1;
      end
      RD_XFER: begin
        if (wcnt_q == WORD_LAST) state_d = RD_DONE;
        else wcnt_d = wcnt_q + 1'b1;
      end
      WR_XFER: begin
        if (wcnt_q == WORD_LAST) state_d = WR_DONE;
        else wcnt_d = wcnt_q + 1'b1;
      end
      RD_DONE: state_d = IDLE;
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lcnt_q  <= '0;
      wcnt_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      wcnt_q  <= wcnt_d;
      base_q  <= base_d;
    end
  end

  // Read line buffer: one word per RD_XFER cycle, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < BLOCK_WORDS; k++) rbuf_q[k] <= '0;
    end else if (state_q == RD_XFER) begin
      rbuf_q[wcnt_q] <= rd_word;
    end
  end

  // Write-back line captured when the request is accepted
  always_ff @(posedge clk) begin
    if (wbuf_ld) begin
      for (int k = 0; k < BLOCK_WORDS; k++)
        wbuf_q[k] <= bus.wdata[32*k +: 32];
    end
  end

  // Array commit; not gated by reset so words already moved persist
  always_ff @(posedge clk) begin
    if (state_q == WR_XFER) mem_q[idx] <= wbuf_q[wcnt_q] ^ 32'(idx);
  end

  for (genvar k = 0; k < BLOCK_WORDS; k++) begin : g_pack
    assign bus.rdata[32*k +: 32] = rbuf_q[k];
  end

  assign bus.l2_ack     = (state_q == RD_DONE);
  assign bus.write_done = (state_q == WR_DONE);
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_l2_block_mem.sv
// tb_l2_block_mem: randomized scoreboard bench against a line-level
// reference model, plus timing checks on two other geometries.
module tb_l2_block_mem;
  localparam int BW    = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 1024;
  localparam int RESP  = LAT + BW + 1;

  typedef struct {
    bit           wr;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;
  bit   mon_en = 1'b0;

  exp_t         sbq[$];
  exp_t         mon_e;
  bit           busy_exp[int];
  logic [31:0]  mem_m [DEPTH];
  logic [127:0] model_rdata = '0;

  l2_block_mem_if #(.BLOCK_WORDS(4)) bus0 ();
  l2_block_mem_if #(.BLOCK_WORDS(1)) bus1 ();
  l2_block_mem_if #(.BLOCK_WORDS(8)) bus2 ();

  l2_block_mem #(
    .BLOCK_WORDS(4), .LATENCY(4), .DEPTH_WORDS(1024)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  l2_block_mem #(
    .BLOCK_WORDS(1), .LATENCY(1), .DEPTH_WORDS(64)
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  l2_block_mem #(
    .BLOCK_WORDS(8), .LATENCY(7), .DEPTH_WORDS(256)
  ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm,
                              input logic [255:0] act,
                              input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic int unsigned base_of(input logic [31:0] a);
    return ((a >> 2) & ~32'(BW - 1)) % DEPTH;
  endfunction

  function automatic logic [127:0] model_read(input logic [31:0] a);
    logic [127:0] l;
    int unsigned  b;
    b = base_of(a);
    for (int k = 0; k < BW; k++) l[32*k +: 32] = mem_m[(b + k) % DEPTH];
    return l;
  endfunction

  function automatic void model_write(input logic [31:0] a,
                                      input logic [127:0] d,
                                      input int nwords);
    int unsigned b;
    b = base_of(a);
    for (int k = 0; k < nwords; k++)
      mem_m[(b + k) % DEPTH] = d[32*k +: 32];
  endfunction

  function automatic void expect_busy(input int from, input int to);
    for (int c = from; c <= to; c++) busy_exp[c] = 1'b1;
  endfunction

  // Monitor: busy every cycle, responses popped from the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", bus0.busy, busy_exp.exists(cyc) ? 1 : 0);
      if (bus0.l2_ack || bus0.write_done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", {bus0.write_done, bus0.l2_ack}, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("resp_kind", {bus0.write_done, bus0.l2_ack},
              mon_e.wr ? 2'b10 : 2'b01);
          chk("resp_cycle", cyc, mon_e.cyc);
          chk("rdata", bus0.rdata, mon_e.data);
        end
      end
    end
  end

  task automatic wait_resp(input bit want_wr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = want_wr ? bus0.write_done : bus0.l2_ack;
    end
    chk("resp_timeout", seen, 1);
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge with the DUT idle
  task automatic do_txn(input bit rd, input bit wr,
                        input logic [31:0] a, input logic [127:0] wd);
    int   n;
    int   s;
    exp_t e;
    n = cyc;
    if (wr) begin
      model_write(a, wd, BW);
      e.wr = 1'b1; e.data = model_rdata; e.cyc = n + RESP;
      sbq.push_back(e);
      expect_busy(n + 1, n + RESP);
    end
    if (rd) begin
      s = wr ? n + RESP + 1 : n;
      model_rdata = model_read(a);
      e.wr = 1'b0; e.data = model_rdata; e.cyc = s + RESP;
      sbq.push_back(e);
      expect_busy(s + 1, s + RESP);
    end
    bus0.addr     = a;
    bus0.wdata    = wd;
    bus0.read_l2  = rd;
    bus0.write_l2 = wr;
    if (!(rd && wr)) begin
      @(posedge clk);
      #1;
      bus0.addr  = $urandom();
      bus0.wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    if (wr) begin
      wait_resp(1'b1);
      bus0.write_l2 = 1'b0;
    end
    if (rd) begin
      wait_resp(1'b0);
      bus0.read_l2 = 1'b0;
    end
  endtask

  int           n;
  int           hit;
  int           op;
  logic [31:0]  a;
  logic [127:0] wd;
  logic [255:0] exp2;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'(i);
    bus0.read_l2 = 0; bus0.write_l2 = 0; bus0.addr = 0; bus0.wdata = 0;
    bus1.read_l2 = 0; bus1.write_l2 = 0; bus1.addr = 0; bus1.wdata = 0;
    bus2.read_l2 = 0; bus2.write_l2 = 0; bus2.addr = 0; bus2.wdata = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", bus0.rdata, 0);
    chk("reset_l2_ack", bus0.l2_ack, 0);
    chk("reset_write_done", bus0.write_done, 0);
    chk("reset_busy", bus0.busy, 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    do_txn(1, 0, 32'h40, '0);
    chk("read_0x40", bus0.rdata, {32'd19, 32'd18, 32'd17, 32'd16});
    do_txn(1, 0, 32'h4C, '0);
    chk("read_0x4C", bus0.rdata, {32'd19, 32'd18, 32'd17, 32'd16});
    do_txn(1, 0, 32'h1000, '0);
    chk("read_wrap", bus0.rdata, {32'd3, 32'd2, 32'd1, 32'd0});

    wd = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    do_txn(0, 1, 32'h40, wd);
    chk("rdata_kept_over_write", bus0.rdata,
        {32'd3, 32'd2, 32'd1, 32'd0});
    do_txn(1, 0, 32'h40, '0);
    chk("readback_0x40", bus0.rdata, wd);
    do_txn(1, 0, 32'h50, '0);
    chk("neighbour_0x50", bus0.rdata, {32'd23, 32'd22, 32'd21, 32'd20});

    do_txn(1, 1, 32'h80,
           {$urandom(), $urandom(), $urandom(), $urandom()});

    wd = {$urandom(), $urandom(), $urandom(), $urandom()};
    n = cyc;
    bus0.addr = 32'hC0; bus0.wdata = wd; bus0.write_l2 = 1'b1;
    model_write(32'hC0, wd, 2);
    expect_busy(n + 1, n + LAT + 2);
    repeat (LAT + 2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus0.write_l2 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_rdata = '0;
    chk("reset_clears_rdata", bus0.rdata, 0);
    repeat (12) begin @(posedge clk); #1; end
    do_txn(1, 0, 32'hC0, '0);
    chk("partial_write", bus0.rdata,
        {32'd51, 32'd50, wd[63:32], wd[31:0]});

    repeat (40) begin
      op = $urandom_range(0, 4);
      a  = ($urandom_range(0, 3) == 0) ? $urandom()
                                       : 32'($urandom_range(0, 511));
      wd = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_txn(op < 2 || op == 4, op >= 2, a, wd);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    n = cyc;
    hit = -1;
    bus1.addr = 32'h1C; bus1.read_l2 = 1'b1;
    for (int i = 0; i < 20 && hit < 0; i++) begin
      @(negedge clk);
      if (bus1.l2_ack) hit = cyc;
    end
    chk("sweep1_ack_cycle", hit, n + 3);
    chk("sweep1_rdata", bus1.rdata, 7);
    @(posedge clk);
    #1;
    bus1.read_l2 = 1'b0;
    @(negedge clk);
    chk("sweep1_pulse_width", bus1.l2_ack, 0);
    @(posedge clk);
    #1;

    n = cyc;
    hit = -1;
    bus2.addr = 32'h3C; bus2.read_l2 = 1'b1;
    for (int k = 0; k < 8; k++) exp2[32*k +: 32] = 32'(8 + k);
    for (int i = 0; i < 40 && hit < 0; i++) begin
      @(negedge clk);
      if (bus2.l2_ack) hit = cyc;
    end
    chk("sweep2_ack_cycle", hit, n + 16);
    chk("sweep2_rdata", bus2.rdata, exp2);
    @(posedge clk);
    #1;
    bus2.read_l2 = 1'b0;
    @(negedge clk);
    chk("sweep2_pulse_width", bus2.l2_ack, 0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
